// File: rtl/serial_adder_arbiter.sv
// Round-robin arbiter sharing one bit-serial full adder (two half adders plus a
// carry flop) between two requesters; LSB-first, WIDTH cycles per addition.
module serial_adder_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic [1:0]       ack,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, sum_q;
   logic             c_q, carry_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       gnt_q, ack_q;
   logic             busy_q, owner_q, last_owner_q;

   logic             ha1_s, ha1_c, ha2_s, ha2_c;
   logic             c_d, winner_d;
   logic [WIDTH-1:0] sum_d;

   always_comb begin
      ha1_s    = a_sh_q[0] ^ b_sh_q[0];
      ha1_c    = a_sh_q[0] & b_sh_q[0];
      ha2_s    = ha1_s ^ c_q;
      ha2_c    = ha1_s & c_q;
      c_d      = ha1_c | ha2_c;
      sum_d    = {ha2_s, sum_sh_q[WIDTH-1:1]};
      // On a tie the requester that was not served last wins.
      winner_d = (req == 2'b11) ? ~last_owner_q : req[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         sum_sh_q     <= '0;
         sum_q        <= '0;
         c_q          <= 1'b0;
         carry_q      <= 1'b0;
         cnt_q        <= '0;
         gnt_q        <= 2'b00;
         ack_q        <= 2'b00;
         busy_q       <= 1'b0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (req != 2'b00) begin
                  owner_q <= winner_d;
                  gnt_q   <= winner_d ? 2'b10 : 2'b01;
                  busy_q  <= 1'b1;
                  a_sh_q  <= winner_d ? a1 : a0;
                  b_sh_q  <= winner_d ? b1 : b0;
                  c_q     <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               sum_sh_q <= sum_d;
               c_q      <= c_d;
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  sum_q        <= sum_d;
                  carry_q      <= c_d;
                  ack_q        <= gnt_q;
                  last_owner_q <= owner_q;
                  state_q      <= DONE;
               end
            end
            DONE: begin
               ack_q   <= 2'b00;
               gnt_q   <= 2'b00;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt   = gnt_q;
   assign busy  = busy_q;
   assign ack   = ack_q;
   assign sum   = sum_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Bench for serial_adder_arbiter: directed scenarios plus randomized traffic,
// all checked against a transaction-level model of arbitration and a+b.
module tb_serial_adder_arbiter;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   req;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   gnt, ack;
   logic         busy, carry;
   logic [W-1:0] sum;

   always #5 clk = ~clk;

   serial_adder_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt(gnt), .busy(busy), .ack(ack), .sum(sum), .carry(carry)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: an operation occupies W+2 cycles from its capture edge.
   bit           m_busy;
   int           m_t;
   int           m_owner;
   int           m_last;
   logic [W:0]   m_res;
   logic [W-1:0] m_sum;
   bit           m_carry;

   int           lat;
   logic [1:0]   seen;
   int           nacks;
   int           ack_cyc [4];
   logic [1:0]   ack_val [4];
   int           racks0, racks1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_t = 0; m_owner = 0; m_last = 1; m_sum = '0; m_carry = 0;
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_reset();
      end else if (m_busy) begin
         m_t++;
         if (m_t == W) begin
            m_sum   = m_res[W-1:0];
            m_carry = m_res[W];
            m_last  = m_owner;
         end else if (m_t == W + 1) begin
            m_busy = 0;
         end
      end else if (req != 2'b00) begin
         if (req == 2'b11) m_owner = (m_last == 1) ? 0 : 1;
         else              m_owner = req[1] ? 1 : 0;
         m_res  = (m_owner == 1) ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
         m_busy = 1;
         m_t    = 0;
      end
   endtask

   task automatic check_outputs();
      logic [1:0] eg;
      eg = m_busy ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("gnt", {30'b0, gnt}, {30'b0, eg});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("ack", {30'b0, ack}, (m_busy && m_t == W) ? {30'b0, eg} : 32'd0);
      chk("sum", {24'b0, sum}, {24'b0, m_sum});
      chk("carry", {31'b0, carry}, {31'b0, m_carry});
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic wait_ack(output int l, output logic [1:0] a);
      bit found;
      found = 0; l = -1; a = 2'b00;
      for (int i = 1; i <= 20 && !found; i++) begin
         cycle();
         if (ack != 2'b00) begin
            found = 1; l = i; a = ack;
         end
      end
      if (!found) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 2'b00;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      check_outputs();
   endtask

   task automatic new_ops(input int i);
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(7, 0) == 0) x = '1;
      if ($urandom_range(7, 0) == 0) y = '1;
      if (i == 0) begin a0 = x; b0 = y; end
      else        begin a1 = x; b1 = y; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single request with overflow
      do_reset();
      chk("rst_gnt", {30'b0, gnt}, 32'd0);
      chk("rst_sum", {24'b0, sum}, 32'd0);
      req = 2'b01; a0 = 8'hFF; b0 = 8'h01;
      cycle();
      chk("t1_gnt", {30'b0, gnt}, 32'h1);
      wait_ack(lat, seen);
      chk("t1_lat", lat, 8);
      chk("t1_ack", {30'b0, seen}, 32'h1);
      chk("t1_sum", {24'b0, sum}, 32'h00);
      chk("t1_carry", {31'b0, carry}, 32'h1);
      req = 2'b00;
      cycle();
      chk("t1_busy_fall", {31'b0, busy}, 32'h0);

      // Simultaneous requests: requester 0 wins the first tie
      do_reset();
      req = 2'b11; a0 = 8'h12; b0 = 8'h34; a1 = 8'hA5; b1 = 8'h5A;
      cycle();
      wait_ack(lat, seen);
      chk("t2_ack0", {30'b0, seen}, 32'h1);
      chk("t2_sum0", {24'b0, sum}, 32'h46);
      chk("t2_carry0", {31'b0, carry}, 32'h0);
      req = 2'b10;
      cycle();
      cycle();
      chk("t2_gnt1_e10", {30'b0, gnt}, 32'h2);
      wait_ack(lat, seen);
      chk("t2_lat1", lat, 8);
      chk("t2_ack1", {30'b0, seen}, 32'h2);
      chk("t2_sum1", {24'b0, sum}, 32'hFF);
      chk("t2_carry1", {31'b0, carry}, 32'h0);
      req = 2'b00;
      cycle();

      // Continuous contention alternates owners every W+2 cycles
      do_reset();
      req = 2'b11; new_ops(0); new_ops(1);
      nacks = 0;
      for (int k = 0; k < 4; k++) begin ack_cyc[k] = 0; ack_val[k] = 2'b00; end
      for (int c = 1; c <= 60 && nacks < 4; c++) begin
         cycle();
         if (ack != 2'b00) begin
            ack_cyc[nacks] = c; ack_val[nacks] = ack; nacks++;
         end
      end
      chk("t3_nacks", nacks, 4);
      for (int k = 0; k < 4; k++) begin
         chk("t3_ack_order", {30'b0, ack_val[k]}, (k % 2 == 0) ? 32'h1 : 32'h2);
         if (k > 0) chk("t3_ack_gap", ack_cyc[k] - ack_cyc[k-1], W + 2);
      end
      req = 2'b00;
      repeat (3) cycle();

      // Operands change and req drops mid-flight
      do_reset();
      req = 2'b01; a0 = 8'h0F; b0 = 8'h01;
      cycle();
      a0 = 8'hFF; b0 = 8'hFF;
      repeat (3) cycle();
      req = 2'b00;
      wait_ack(lat, seen);
      chk("t4_ack", {30'b0, seen}, 32'h1);
      chk("t4_sum", {24'b0, sum}, 32'h10);
      chk("t4_carry", {31'b0, carry}, 32'h0);
      cycle();

      // Asynchronous reset mid-operation discards it
      do_reset();
      req = 2'b01; a0 = 8'hC3; b0 = 8'h7E;
      cycle();
      repeat (5) cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_gnt", {30'b0, gnt}, 32'h0);
      chk("t5_rst_busy", {31'b0, busy}, 32'h0);
      chk("t5_rst_ack", {30'b0, ack}, 32'h0);
      chk("t5_rst_sum", {24'b0, sum}, 32'h0);
      model_reset();
      req = 2'b00;
      repeat (2) cycle();
      rst_n = 1'b1;
      req = 2'b01; a0 = 8'h80; b0 = 8'h80;
      cycle();
      wait_ack(lat, seen);
      chk("t5_sum", {24'b0, sum}, 32'h00);
      chk("t5_carry", {31'b0, carry}, 32'h1);
      req = 2'b00;
      cycle();

      // Zero operands on requester 1; previous result held until DONE
      req = 2'b10; a1 = 8'h00; b1 = 8'h00;
      cycle();
      cycle();
      chk("t6_hold_carry", {31'b0, carry}, 32'h1);
      wait_ack(lat, seen);
      chk("t6_ack", {30'b0, seen}, 32'h2);
      chk("t6_carry", {31'b0, carry}, 32'h0);
      chk("t6_sum", {24'b0, sum}, 32'h00);
      req = 2'b00;
      cycle();

      // Randomized traffic
      do_reset();
      racks0 = 0; racks1 = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         cycle();
         if (ack[0]) racks0++;
         if (ack[1]) racks1++;
         for (int i = 0; i < 2; i++) begin
            if (req[i] && ack[i]) begin
               if ($urandom_range(1, 0) == 1) new_ops(i);
               else req[i] = 1'b0;
            end else if (!req[i]) begin
               if ($urandom_range(9, 0) < 3) begin
                  req[i] = 1'b1; new_ops(i);
               end
            end else if (busy && gnt[i]) begin
               if ($urandom_range(19, 0) == 0) req[i] = 1'b0;
               else if ($urandom_range(3, 0) == 0) new_ops(i);
            end
         end
      end
      chk("rand_acks0_seen", {31'b0, racks0 > 0}, 32'h1);
      chk("rand_acks1_seen", {31'b0, racks1 > 0}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_arbiter.md
# serial_adder_arbiter

Shares a single bit-serial full-adder cell, built from two half-adder stages and a carry flop, between two requesters. Arbitrates round-robin, sequences the WIDTH-bit addition one bit per clock (LSB first), and returns sum and carry-out with a one-cycle acknowledge to the winner. Sits between the requesting datapath blocks and the adder primitive, and trades latency for area.

## Interface
- WIDTH, 8, operand and sum width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  2  per-requester request; bit i held high until ack[i]
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- gnt  output  2  one-hot current owner while busy, 0 otherwise
- busy  output  1  operation in progress (SHIFT or DONE)
- ack  output  2  one-cycle pulse to owner; sum/carry valid
- sum  output  WIDTH  result of last completed operation
- carry  output  1  carry-out of last completed operation

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if req≠0, pick winner, capture its a/b into shift registers, clear carry flop and bit counter, set gnt, go to SHIFT. If req==0, stay.
- Arbitration: single request → that requester wins. Both requesting → winner is the requester not served last (last_owner). last_owner resets to 1, so requester 0 wins the first tie.
- SHIFT: per cycle, bit = a_sh[0]^b_sh[0]^c and c_next = (a&b)|(c&(a^b)) via two half adders. Shift a_sh/b_sh right. Shift bit into the MSB of the internal sum shift register. Increment counter. After the WIDTH-th bit, go to DONE.
- DONE: load sum/carry outputs from the internal registers, pulse ack[owner], update last_owner. Next cycle return to IDLE with gnt=0 and busy=0.
- sum/carry change only on DONE entry and hold between operations.
- Operands are sampled once, at capture. Later changes to a*/b* or req have no effect on the operation in flight.
- req dropped mid-operation: the operation still completes and ack still pulses.
- req held after ack: treated as a new request in IDLE and subject to round-robin, so the other requester, if pending, wins.
- Overflow: carry = bit WIDTH of a+b. sum = (a+b) mod 2^WIDTH.
- Reset (any state, any cycle): state=IDLE, gnt=0, busy=0, ack=0, sum=0, carry=0, last_owner=1, internal regs cleared. An in-flight operation is discarded with no ack.

## Timing
- Capture edge E0: request is sampled in IDLE. After E0, busy=1 and gnt valid.
- Edges E1..E_WIDTH compute bits 0..WIDTH-1.
- After E_WIDTH: state DONE, ack[owner]=1, sum/carry valid. Latency is WIDTH cycles from the capture edge to ack rising.
- After E_WIDTH+1: IDLE, ack=0, gnt=0, busy=0.
- Earliest next capture is E_WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- ack is exactly one cycle wide and never asserted for both bits.
- All outputs are registered. No combinational path from req or operands to any output.

## Test plan
- Reset, then req=2'b01, a0=8'hFF, b0=8'h01 → gnt=01 after E0; ack=01 for one cycle after E8 with sum=8'h00, carry=1; busy falls after E9.
- Reset, then req=2'b11 simultaneously, a0=8'h12, b0=8'h34, a1=8'hA5, b1=8'h5A → first ack=01 with sum=8'h46, carry=0; requester 1 captured at E10; ack=10 with sum=8'hFF, carry=0.
- Hold req=2'b11 continuously for 4 operations → acks alternate 01,10,01,10, each 10 cycles apart.
- Change a0 and b0 mid-SHIFT after capturing 8'h0F+8'h01, and drop req0 at bit 3 → sum=8'h10, carry=0; ack=01 still pulses.
- Assert rst_n=0 during bit 5 of an active operation → all outputs are 0 immediately; no ack. After release, a new req0 with 8'h80+8'h80 → sum=8'h00, carry=1.
- Zero operands, 8'h00+8'h00 on requester 1 → sum=8'h00, carry=0; the previous sum/carry values stay held until DONE.
